ordenator_oet: RTL and testbench
================================

Name: ordenator_oet

Overview:
- Parametrised successor of the team's bubble-sort ordenator block.
- Sorts DATA_SIZE words of DATA_WIDTH bits using odd-even transposition: one compare/swap phase per clock, all disjoint pairs in a phase in parallel.
- Adds a start/ready handshake, a per-job ascending/descending mode, optional signed compare and an optional early-exit feature.
- Sits between a data-capture front end and downstream consumers of the ordered vector.

Parameters:
- DATA_WIDTH, 8, width of each element in bits (must be >= 1).
- DATA_SIZE, 9, number of elements (must be >= 2).
- SIGNED, 0, 1 = elements compared as two's complement; 0 = unsigned.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request; sampled only when not busy.
- descending_i  input  1  0 = ascending, 1 = descending; latched with start.
- numbers_i  input  DATA_WIDTH x DATA_SIZE  unpacked input vector; latched with start.
- numbers_o  output  DATA_WIDTH x DATA_SIZE  registered sorted vector.
- busy_o  output  1  high while a sort is in progress.
- ready_o  output  1  high when numbers_o holds a completed result.
- phases_o  output  $clog2(DATA_SIZE+1)  number of phases executed by the last job.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - Working array, numbers_o, phase counter and phases_o = 0.
  - busy_o = 0, ready_o = 0.
- FSM states: IDLE, SORT, DONE. DONE accepts start exactly as IDLE does.
- Start accept (IDLE or DONE, start_i = 1 at an edge):
  - Working array <= numbers_i; mode <= descending_i; phase counter <= 0.
  - busy_o <= 1, ready_o <= 0; state -> SORT.
  - numbers_o keeps its previous value.
- SORT, one phase per edge:
  - Phase k even: compare pairs (0,1), (2,3), ...
  - Phase k odd: compare pairs (1,2), (3,4), ...
  - Unpaired end element is untouched. Phase counter increments.
- Swap rule:
  - Ascending: swap when a[i] > a[i+1], strictly.
  - Descending: swap when a[i] < a[i+1], strictly.
  - Equal elements are never swapped, so the sort is stable.
  - SIGNED selects signed or unsigned compare. No width growth, no arithmetic on data.
- Termination: at the edge applying phase DATA_SIZE-1:
  - numbers_o <= final array; phases_o <= DATA_SIZE.
  - busy_o <= 0, ready_o <= 1; state -> DONE.
- Latency (without early exit): ready_o rises exactly DATA_SIZE edges after the start-accept edge. busy_o is high for exactly DATA_SIZE cycles.
- start_i while busy_o = 1 is ignored; numbers_i and descending_i changes during SORT have no effect.
- Start in DONE: ready_o drops on the accept edge. Back-to-back jobs have no idle cycle.
- ready_o and numbers_o hold indefinitely in DONE until the next start or reset.
- Reset mid-SORT: job is abandoned and all outputs return to reset values immediately (asynchronous).
- Odd and even DATA_SIZE are both supported. DATA_SIZE phases guarantee a sorted result for any input.

Optional Feature:
- Macro: ORDENATOR_EARLY_EXIT_EN.
- Defined:
  - A per-phase swap flag is kept.
  - If phase k (k >= 1) and phase k-1 both made no swap, the job terminates at the phase-k edge, with the same actions as normal termination.
  - phases_o = k+1. Minimum job length is 2 phases.
  - If the early condition is not met, the job ends at phase DATA_SIZE-1 as normal.
- Not defined: fixed DATA_SIZE phases; no swap-flag logic is synthesised; phases_o is always DATA_SIZE.

Test Plan:
- Reset: assert rst_i mid-idle and mid-SORT (phase 4) -> busy_o = 0, ready_o = 0, numbers_o all 0, phases_o = 0 immediately; a later start runs normally.
- Ascending, defaults: {200,3,77,3,255,0,19,128,64} -> {0,3,3,19,64,77,128,200,255}; ready_o high exactly 9 edges after accept; busy_o high 9 cycles.
- Descending, same input -> {255,200,128,77,64,19,3,3,0}. Worst case {8,7,6,5,4,3,2,1,0} ascending -> {0..8} after 9 phases.
- SIGNED = 1, DATA_SIZE = 4: {8'h7F,8'h80,8'h00,8'hFF} ascending -> {8'h80,8'hFF,8'h00,8'h7F}. Same data with SIGNED = 0 -> {8'h00,8'h7F,8'h80,8'hFF}.
- Handshake: pulse start_i with new data at phase 3 -> ignored, result matches the first vector. Start on the same edge ready_o is observed high -> ready_o drops next edge, second result correct.
- ORDENATOR_EARLY_EXIT_EN: sorted input {1..9} -> ready_o 2 edges after accept, phases_o = 2. Without the macro -> 9 edges, phases_o = 9. Reversed input -> 9 phases in both builds.

Source files
------------

// File: rtl/ordenator_oet.sv
// Odd-even transposition sorter: one compare/swap phase per clock, DATA_SIZE phases per job,
// start accepted in IDLE/DONE only; `ORDENATOR_EARLY_EXIT_EN ends a job after two swap-free phases.
module ordenator_oet #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 9,
  parameter int SIGNED     = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              descending_i,
  input  logic [DATA_WIDTH-1:0]             numbers_i [DATA_SIZE],
  output logic [DATA_WIDTH-1:0]             numbers_o [DATA_SIZE],
  output logic                              busy_o,
  output logic                              ready_o,
  output logic [$clog2(DATA_SIZE+1)-1:0]    phases_o
);

  localparam int PW = $clog2(DATA_SIZE + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   work     [DATA_SIZE];
  logic [DATA_WIDTH-1:0]   work_nxt [DATA_SIZE];
  logic                    mode;
  logic [PW-1:0]           phase;
  logic                    last_phase;
  logic                    accept;
`ifdef ORDENATOR_EARLY_EXIT_EN
  logic                    any_swap;
  logic                    prev_swap;
`endif

  // Strict compare in the active direction; equal elements never move.
  function automatic logic out_of_order(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b,
                                        input logic                  desc);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return desc ? lt : gt;
  endfunction

  always_comb begin
    work_nxt = work;
`ifdef ORDENATOR_EARLY_EXIT_EN
    any_swap = 1'b0;
`endif
    for (int i = 0; i < DATA_SIZE - 1; i++) begin
      if ((i % 2) == int'(phase[0]) && out_of_order(work[i], work[i+1], mode)) begin
        work_nxt[i]   = work[i+1];
        work_nxt[i+1] = work[i];
`ifdef ORDENATOR_EARLY_EXIT_EN
        any_swap = 1'b1;
`endif
      end
    end
  end

`ifdef ORDENATOR_EARLY_EXIT_EN
  assign last_phase = (phase == LAST_PHASE) ||
                      ((phase != '0) && !any_swap && !prev_swap);
`else
  assign last_phase = (phase == LAST_PHASE);
`endif

  assign accept = (state != SORT) && start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_i)    state_nxt = SORT;
      SORT:       if (last_phase) state_nxt = DONE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work      <= '{default: '0};
      numbers_o <= '{default: '0};
      mode      <= 1'b0;
      phase     <= '0;
      phases_o  <= '0;
`ifdef ORDENATOR_EARLY_EXIT_EN
      prev_swap <= 1'b0;
`endif
    end else if (accept) begin
      work  <= numbers_i;
      mode  <= descending_i;
      phase <= '0;
`ifdef ORDENATOR_EARLY_EXIT_EN
      prev_swap <= 1'b0;
`endif
    end else if (state == SORT) begin
      work  <= work_nxt;
      phase <= phase + PW'(1);
`ifdef ORDENATOR_EARLY_EXIT_EN
      prev_swap <= any_swap;
`endif
      if (last_phase) begin
        numbers_o <= work_nxt;
`ifdef ORDENATOR_EARLY_EXIT_EN
        phases_o  <= phase + PW'(1);
`else
        phases_o  <= PW'(DATA_SIZE);
`endif
      end
    end
  end

  assign busy_o  = (state == SORT);
  assign ready_o = (state == DONE);

endmodule

// File: tb/tb_ordenator_oet.sv
// Directed bench for ordenator_oet: default 9x8 unsigned instance plus 4-element signed/unsigned pair.
module tb_ordenator_oet;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       desc;
  logic [7:0] din  [9];
  logic [7:0] dout [9];
  logic       busy;
  logic       ready;
  logic [3:0] phases;

  logic       start4;
  logic       desc4;
  logic [7:0] din4   [4];
  logic [7:0] dout_s [4];
  logic [7:0] dout_u [4];
  logic       busy_s, busy_u, ready_s, ready_u;
  logic [2:0] phases_s, phases_u;

  logic [7:0] exp9  [9];
  logic [7:0] exp_s [4];
  logic [7:0] exp_u [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ordenator_oet dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .descending_i(desc),
    .numbers_i(din), .numbers_o(dout), .busy_o(busy), .ready_o(ready), .phases_o(phases)
  );

  ordenator_oet #(.DATA_WIDTH(8), .DATA_SIZE(4), .SIGNED(1)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .descending_i(desc4),
    .numbers_i(din4), .numbers_o(dout_s), .busy_o(busy_s), .ready_o(ready_s), .phases_o(phases_s)
  );

  ordenator_oet #(.DATA_WIDTH(8), .DATA_SIZE(4), .SIGNED(0)) dut_u (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .descending_i(desc4),
    .numbers_i(din4), .numbers_o(dout_u), .busy_o(busy_u), .ready_o(ready_u), .phases_o(phases_u)
  );

  task automatic start_job(input logic d);
    @(negedge clk);
    desc  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accept edge; lat = edges until ready, -1 on timeout.
  task automatic wait_ready(output int lat, output int bcnt);
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat, bcnt;
    #2;
    checks++; if (busy !== 1'b0 || ready !== 1'b0 || phases !== 4'd0) begin
      errors++; $display("FAIL reset_init: busy=%b ready=%b phases=%0d required 0 0 0", busy, ready, phases);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== 8'd0) begin
        errors++; $display("FAIL reset_init_num[%0d]: got %0d required 0", i, dout[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    din = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
    start_job(1'b0);
    wait_ready(lat, bcnt);
    // Reset while idle in DONE.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b0 || phases !== 4'd0 || dout[0] !== 8'd0 || dout[8] !== 8'd0) begin
      errors++; $display("FAIL reset_idle: busy=%b ready=%b phases=%0d n0=%0d n8=%0d required all 0",
                         busy, ready, phases, dout[0], dout[8]);
    end
    @(negedge clk);
    rst = 1'b0;
    start_job(1'b0);
    wait_ready(lat, bcnt);
    start_job(1'b1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b0 || phases !== 4'd0) begin
      errors++; $display("FAIL reset_sort: busy=%b ready=%b phases=%0d required 0 0 0", busy, ready, phases);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== 8'd0) begin
        errors++; $display("FAIL reset_sort_num[%0d]: got %0d required 0", i, dout[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ascending();
    int lat, bcnt;
    din  = '{8'd200, 8'd3, 8'd77, 8'd3, 8'd255, 8'd0, 8'd19, 8'd128, 8'd64};
    exp9 = '{8'd0, 8'd3, 8'd3, 8'd19, 8'd64, 8'd77, 8'd128, 8'd200, 8'd255};
    start_job(1'b0);
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL asc_accept: busy=%b ready=%b required 1 0", busy, ready);
    end
    wait_ready(lat, bcnt);
    checks++; if (lat !== 9) begin
      errors++; $display("FAIL asc_latency: got %0d edges required 9", lat);
    end
    checks++; if (bcnt !== 9) begin
      errors++; $display("FAIL asc_busy_cycles: got %0d required 9", bcnt);
    end
    checks++; if (phases !== 4'd9) begin
      errors++; $display("FAIL asc_phases: got %0d required 9", phases);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== exp9[i]) begin
        errors++; $display("FAIL asc_num[%0d]: got %0d required %0d", i, dout[i], exp9[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1 || dout[8] !== 8'd255) begin
      errors++; $display("FAIL asc_hold: ready=%b n8=%0d required 1 255", ready, dout[8]);
    end
  endtask

  task automatic test_descending();
    int lat, bcnt;
    din  = '{8'd200, 8'd3, 8'd77, 8'd3, 8'd255, 8'd0, 8'd19, 8'd128, 8'd64};
    exp9 = '{8'd255, 8'd200, 8'd128, 8'd77, 8'd64, 8'd19, 8'd3, 8'd3, 8'd0};
    start_job(1'b1);
    checks++; if (ready !== 1'b0 || dout[8] !== 8'd255) begin
      errors++; $display("FAIL desc_accept: ready=%b n8=%0d required 0 255", ready, dout[8]);
    end
    wait_ready(lat, bcnt);
`ifndef ORDENATOR_EARLY_EXIT_EN
    checks++; if (lat !== 9) begin
      errors++; $display("FAIL desc_latency: got %0d edges required 9", lat);
    end
`endif
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== exp9[i]) begin
        errors++; $display("FAIL desc_num[%0d]: got %0d required %0d", i, dout[i], exp9[i]);
      end
    end
  endtask

  task automatic test_worst_case();
    int lat, bcnt;
    din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    exp9 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    start_job(1'b0);
    wait_ready(lat, bcnt);
    checks++; if (lat !== 9 || phases !== 4'd9) begin
      errors++; $display("FAIL worst_latency: lat=%0d phases=%0d required 9 9", lat, phases);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== exp9[i]) begin
        errors++; $display("FAIL worst_num[%0d]: got %0d required %0d", i, dout[i], exp9[i]);
      end
    end
  endtask

  task automatic test_signed();
    int lat;
    din4  = '{8'h7F, 8'h80, 8'h00, 8'hFF};
    exp_s = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    exp_u = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    @(negedge clk);
    desc4  = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready_s && ready_u) begin
        lat = n;
        break;
      end
    end
`ifndef ORDENATOR_EARLY_EXIT_EN
    checks++; if (lat !== 4 || phases_s !== 3'd4 || phases_u !== 3'd4) begin
      errors++; $display("FAIL size4_latency: lat=%0d ps=%0d pu=%0d required 4 4 4", lat, phases_s, phases_u);
    end
`else
    checks++; if (lat < 2 || lat > 4) begin
      errors++; $display("FAIL size4_latency: lat=%0d required 2..4", lat);
    end
`endif
    checks++; if (busy_s !== 1'b0 || busy_u !== 1'b0) begin
      errors++; $display("FAIL size4_busy: busy_s=%b busy_u=%b required 0 0", busy_s, busy_u);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout_s[i] !== exp_s[i]) begin
        errors++; $display("FAIL signed_num[%0d]: got %h required %h", i, dout_s[i], exp_s[i]);
      end
      checks++; if (dout_u[i] !== exp_u[i]) begin
        errors++; $display("FAIL unsigned_num[%0d]: got %h required %h", i, dout_u[i], exp_u[i]);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    int lat;
    din  = '{8'd200, 8'd3, 8'd77, 8'd3, 8'd255, 8'd0, 8'd19, 8'd128, 8'd64};
    exp9 = '{8'd0, 8'd3, 8'd3, 8'd19, 8'd64, 8'd77, 8'd128, 8'd200, 8'd255};
    start_job(1'b0);
    repeat (3) @(posedge clk);
    #1;
    din   = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    desc  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 5; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 9) begin
      errors++; $display("FAIL ignore_latency: got %0d edges required 9", lat);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== exp9[i]) begin
        errors++; $display("FAIL ignore_num[%0d]: got %0d required %0d", i, dout[i], exp9[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL ignore_no_restart: busy=%b ready=%b required 0 1", busy, ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    din = '{8'd200, 8'd3, 8'd77, 8'd3, 8'd255, 8'd0, 8'd19, 8'd128, 8'd64};
    start_job(1'b0);
    wait_ready(lat, bcnt);
    din   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    exp9  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    desc  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (ready !== 1'b0 || busy !== 1'b1 || dout[0] !== 8'd0) begin
      errors++; $display("FAIL b2b_accept: ready=%b busy=%b n0=%0d required 0 1 0", ready, busy, dout[0]);
    end
    wait_ready(lat, bcnt);
    checks++; if (lat !== 9 || phases !== 4'd9) begin
      errors++; $display("FAIL b2b_latency: lat=%0d phases=%0d required 9 9", lat, phases);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== exp9[i]) begin
        errors++; $display("FAIL b2b_num[%0d]: got %0d required %0d", i, dout[i], exp9[i]);
      end
    end
  endtask

  task automatic test_early_exit();
    int lat, bcnt;
    int exp_lat;
`ifdef ORDENATOR_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 9;
`endif
    din  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    exp9 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    start_job(1'b0);
    wait_ready(lat, bcnt);
    checks++; if (lat !== exp_lat || int'(phases) !== exp_lat) begin
      errors++; $display("FAIL early_sorted: lat=%0d phases=%0d required %0d %0d", lat, phases, exp_lat, exp_lat);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== exp9[i]) begin
        errors++; $display("FAIL early_sorted_num[%0d]: got %0d required %0d", i, dout[i], exp9[i]);
      end
    end
    din = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    start_job(1'b0);
    wait_ready(lat, bcnt);
    checks++; if (lat !== 9 || phases !== 4'd9) begin
      errors++; $display("FAIL early_reversed: lat=%0d phases=%0d required 9 9", lat, phases);
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (dout[i] !== exp9[i]) begin
        errors++; $display("FAIL early_reversed_num[%0d]: got %0d required %0d", i, dout[i], exp9[i]);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    desc   = 1'b0;
    start4 = 1'b0;
    desc4  = 1'b0;
    din    = '{default: 8'd0};
    din4   = '{default: 8'd0};
    test_reset();
    test_ascending();
    test_descending();
    test_worst_case();
    test_signed();
    test_ignore_busy_start();
    test_back_to_back();
    test_early_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
